// File: rtl/alarm_pkg.sv
// Shared constants for the anti-theft alarm input front-end.
// Index localparams name the bit positions of the six-bit panel input vector.
package alarm_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEFAULT_CNT_W           = 5;

    localparam int unsigned NUM_INPUTS      = 6;
    localparam int unsigned IDX_IGNITION    = 0;
    localparam int unsigned IDX_DOOR_DRIVER = 1;
    localparam int unsigned IDX_DOOR_PASS   = 2;
    localparam int unsigned IDX_REPROGRAM   = 3;
    localparam int unsigned IDX_BRAKE       = 4;
    localparam int unsigned IDX_HIDDEN_SW   = 5;

endpackage

// File: rtl/debounce_bit.sv
// One raw input: two-flop synchronizer followed by a saturating-run debounce filter.
// The stable value flips only after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_bit
    import alarm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Any return to equality discards the run, so counts never accumulate.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Alarm panel input front-end: six debounced levels plus a reprogram rising-edge pulse.
// Define INPUT_CONDITIONER_EVENTS_EN to add door_open_evt and ignition_off_evt pulses.
module input_conditioner
    import alarm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic ignition_raw,
    input  logic door_driver_raw,
    input  logic door_pass_raw,
    input  logic reprogram_raw,
    input  logic brake_raw,
    input  logic hidden_sw_raw,
    output logic ignition,
    output logic door_driver,
    output logic door_pass,
    output logic reprogram,
    output logic reprogram_pulse,
    output logic brake,
    output logic hidden_sw
`ifdef INPUT_CONDITIONER_EVENTS_EN
    ,
    output logic door_open_evt,
    output logic ignition_off_evt
`endif
);

    logic [NUM_INPUTS-1:0] raw_vec;
    logic [NUM_INPUTS-1:0] stable_vec;
    logic                  reprogram_d;

    assign raw_vec[IDX_IGNITION]    = ignition_raw;
    assign raw_vec[IDX_DOOR_DRIVER] = door_driver_raw;
    assign raw_vec[IDX_DOOR_PASS]   = door_pass_raw;
    assign raw_vec[IDX_REPROGRAM]   = reprogram_raw;
    assign raw_vec[IDX_BRAKE]       = brake_raw;
    assign raw_vec[IDX_HIDDEN_SW]   = hidden_sw_raw;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clock (clock),
            .reset (reset),
            .raw   (raw_vec[i]),
            .stable(stable_vec[i])
        );
    end

    // Outputs come straight from the filter flops; no raw-to-output path.
    assign ignition    = stable_vec[IDX_IGNITION];
    assign door_driver = stable_vec[IDX_DOOR_DRIVER];
    assign door_pass   = stable_vec[IDX_DOOR_PASS];
    assign reprogram   = stable_vec[IDX_REPROGRAM];
    assign brake       = stable_vec[IDX_BRAKE];
    assign hidden_sw   = stable_vec[IDX_HIDDEN_SW];

    // Both delay and pulse reset to 0, so reset release never looks like an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            reprogram_d     <= 1'b0;
            reprogram_pulse <= 1'b0;
        end else begin
            reprogram_d     <= reprogram;
            reprogram_pulse <= reprogram & ~reprogram_d;
        end
    end

`ifdef INPUT_CONDITIONER_EVENTS_EN
    logic door_any;
    logic door_any_d;
    logic ignition_d;

    // Edge on the OR of both doors: a second door opening is not a new event.
    assign door_any = door_driver | door_pass;

    always_ff @(posedge clock) begin
        if (reset) begin
            door_any_d       <= 1'b0;
            ignition_d       <= 1'b0;
            door_open_evt    <= 1'b0;
            ignition_off_evt <= 1'b0;
        end else begin
            door_any_d       <= door_any;
            ignition_d       <= ignition;
            door_open_evt    <= door_any & ~door_any_d;
            ignition_off_evt <= ~ignition & ignition_d;
        end
    end
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (DEBOUNCE_CYCLES=16); with
// INPUT_CONDITIONER_EVENTS_EN a second instance with DEBOUNCE_CYCLES=1 covers the event pulses.
module tb_input_conditioner;

    logic clock;
    logic reset;
    logic ignition_raw, door_driver_raw, door_pass_raw;
    logic reprogram_raw, brake_raw, hidden_sw_raw;
    logic ignition, door_driver, door_pass, reprogram, reprogram_pulse, brake, hidden_sw;

    int n_cmp;
    int n_err;

    input_conditioner #(.DEBOUNCE_CYCLES(16), .CNT_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ignition_raw   (ignition_raw),
        .door_driver_raw(door_driver_raw),
        .door_pass_raw  (door_pass_raw),
        .reprogram_raw  (reprogram_raw),
        .brake_raw      (brake_raw),
        .hidden_sw_raw  (hidden_sw_raw),
        .ignition       (ignition),
        .door_driver    (door_driver),
        .door_pass      (door_pass),
        .reprogram      (reprogram),
        .reprogram_pulse(reprogram_pulse),
        .brake          (brake),
        .hidden_sw      (hidden_sw)
`ifdef INPUT_CONDITIONER_EVENTS_EN
        ,
        .door_open_evt   (),
        .ignition_off_evt()
`endif
    );

`ifdef INPUT_CONDITIONER_EVENTS_EN
    logic e_ign_raw, e_dd_raw, e_dp_raw;
    logic e_ign, e_dd, e_dp, e_rep, e_rep_p, e_brk, e_hid;
    logic e_door_evt, e_ign_off_evt;

    input_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(5)) dut_evt (
        .clock           (clock),
        .reset           (reset),
        .ignition_raw    (e_ign_raw),
        .door_driver_raw (e_dd_raw),
        .door_pass_raw   (e_dp_raw),
        .reprogram_raw   (1'b0),
        .brake_raw       (1'b0),
        .hidden_sw_raw   (1'b0),
        .ignition        (e_ign),
        .door_driver     (e_dd),
        .door_pass       (e_dp),
        .reprogram       (e_rep),
        .reprogram_pulse (e_rep_p),
        .brake           (e_brk),
        .hidden_sw       (e_hid),
        .door_open_evt   (e_door_evt),
        .ignition_off_evt(e_ign_off_evt)
    );
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [5:0] outs();
        return {hidden_sw, brake, reprogram, door_pass, door_driver, ignition};
    endfunction

    task automatic set_all_raw(input logic v);
        ignition_raw    = v;
        door_driver_raw = v;
        door_pass_raw   = v;
        reprogram_raw   = v;
        brake_raw       = v;
        hidden_sw_raw   = v;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        set_all_raw(1'b1);
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++;
            if ({reprogram_pulse, outs()} !== 7'h00) begin
                n_err++;
                $display("FAIL reset_hold edge %0d: got %b expected 0000000", i, {reprogram_pulse, outs()});
            end
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            n_cmp++;
            if (outs() !== ((i >= 18) ? 6'h3f : 6'h00)) begin
                n_err++;
                $display("FAIL reset_release edge %0d: got %b expected %b", i, outs(),
                         (i >= 18) ? 6'h3f : 6'h00);
            end
            n_cmp++;
            if (reprogram_pulse !== (i == 19)) begin
                n_err++;
                $display("FAIL reset_release_pulse edge %0d: got %b expected %b", i, reprogram_pulse, i == 19);
            end
        end
        @(negedge clock);
        set_all_raw(1'b0);
        for (int i = 1; i <= 20; i++) step();
        n_cmp++;
        if ({reprogram_pulse, outs()} !== 7'h00) begin
            n_err++;
            $display("FAIL reset_all_low: got %b expected 0000000", {reprogram_pulse, outs()});
        end
    endtask

    task automatic test_glitch();
        @(negedge clock);
        door_pass_raw = 1'b1;
        for (int i = 1; i <= 10; i++) step();
        @(negedge clock);
        door_pass_raw = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            n_cmp++;
            if (door_pass !== 1'b0) begin
                n_err++;
                $display("FAIL glitch_reject edge %0d: got %b expected 0", i, door_pass);
            end
        end
        // 16-cycle pulse is just long enough; the drop then takes another 18 edges.
        @(negedge clock);
        door_pass_raw = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 16) begin
                @(negedge clock);
                door_pass_raw = 1'b0;
            end
            n_cmp++;
            if (door_pass !== (i >= 18 && i < 34)) begin
                n_err++;
                $display("FAIL glitch_accept edge %0d: got %b expected %b", i, door_pass, i >= 18 && i < 34);
            end
        end
    endtask

    task automatic test_bounce_restart();
        @(negedge clock);
        ignition_raw = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            step();
            if (i == 12) begin
                @(negedge clock);
                ignition_raw = 1'b0;
            end else if (i == 13) begin
                @(negedge clock);
                ignition_raw = 1'b1;
            end
            n_cmp++;
            if (ignition !== (i >= 31)) begin
                n_err++;
                $display("FAIL bounce_restart edge %0d: got %b expected %b", i, ignition, i >= 31);
            end
        end
        @(negedge clock);
        ignition_raw = 1'b0;
        for (int i = 1; i <= 20; i++) step();
        n_cmp++;
        if (ignition !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_release: got %b expected 0", ignition);
        end
    endtask

    task automatic test_reprogram();
        int pulses;
        pulses = 0;
        @(negedge clock);
        reprogram_raw = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (reprogram_pulse === 1'b1) pulses++;
            if (i == 19) begin
                n_cmp++;
                if (reprogram_pulse !== 1'b1) begin
                    n_err++;
                    $display("FAIL reprogram_pulse_at_19: got %b expected 1", reprogram_pulse);
                end
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL reprogram_pulse_count: got %0d expected 1", pulses);
        end
        n_cmp++;
        if (reprogram !== 1'b1) begin
            n_err++;
            $display("FAIL reprogram_level_held: got %b expected 1", reprogram);
        end
        pulses = 0;
        @(negedge clock);
        reprogram_raw = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (reprogram_pulse === 1'b1) pulses++;
        end
        n_cmp++;
        if ({pulses != 0, reprogram} !== 2'b00) begin
            n_err++;
            $display("FAIL reprogram_release: pulses %0d level %b, expected 0 and 0", pulses, reprogram);
        end
    endtask

    task automatic test_reset_mid_count();
        @(negedge clock);
        brake_raw = 1'b1;
        for (int i = 1; i <= 12; i++) step();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            n_cmp++;
            if (brake !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_hold edge %0d: got %b expected 0", i, brake);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            step();
            n_cmp++;
            if (brake !== (i >= 18)) begin
                n_err++;
                $display("FAIL reset_mid_release edge %0d: got %b expected %b", i, brake, i >= 18);
            end
        end
        @(negedge clock);
        brake_raw = 1'b0;
        for (int i = 1; i <= 20; i++) step();
    endtask

`ifdef INPUT_CONDITIONER_EVENTS_EN
    task automatic test_events();
        int door_evts;
        int ign_evts;
        door_evts = 0;
        ign_evts  = 0;
        @(negedge clock);
        e_dd_raw = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (i == 5) begin
                @(negedge clock);
                e_dp_raw = 1'b1;
            end
            if (e_door_evt === 1'b1) door_evts++;
            if (i == 4) begin
                n_cmp++;
                if (e_door_evt !== 1'b1) begin
                    n_err++;
                    $display("FAIL door_evt_at_4: got %b expected 1", e_door_evt);
                end
            end
        end
        n_cmp++;
        if (door_evts != 1) begin
            n_err++;
            $display("FAIL door_evt_count: got %0d expected 1", door_evts);
        end
        @(negedge clock);
        e_ign_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (e_ign_off_evt === 1'b1) ign_evts++;
        end
        @(negedge clock);
        e_ign_raw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (e_ign_off_evt === 1'b1) ign_evts++;
            if (i == 4) begin
                n_cmp++;
                if (e_ign_off_evt !== 1'b1) begin
                    n_err++;
                    $display("FAIL ign_off_evt_at_4: got %b expected 1", e_ign_off_evt);
                end
            end
        end
        n_cmp++;
        if (ign_evts != 1) begin
            n_err++;
            $display("FAIL ign_off_evt_count: got %0d expected 1", ign_evts);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        set_all_raw(1'b0);
`ifdef INPUT_CONDITIONER_EVENTS_EN
        e_ign_raw = 1'b0;
        e_dd_raw  = 1'b0;
        e_dp_raw  = 1'b0;
`endif
        repeat (2) @(posedge clock);
        test_reset();
        test_glitch();
        test_bounce_restart();
        test_reprogram();
        test_reset_mid_count();
`ifdef INPUT_CONDITIONER_EVENTS_EN
        test_events();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
